trunc_mult_err_monitor: RTL and testbench
=========================================

# trunc_mult_err_monitor

Sequential error-statistics stage placed directly downstream of the 8x8 truncated Dadda multiplier. For each accepted sample it takes the operands and the multiplier's approximate product, computes the exact product internally, and forms the absolute error distance. Over a programmable number of samples it accumulates error count, error-distance sum and maximum error distance. The results drive characterisation runs (ER, MED, max ED) of the approximate multiplier family.

## Interface
- W, 8: operand width. The approximate and exact products are 2W bits wide.
- CNT_W, 16: width of the sample counter and of `num_samples`.
- ACC_W, 2*W+CNT_W: width of the error-distance sum. It cannot overflow for any legal run.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run. It is sampled only in IDLE or DONE.
- num_samples  in  CNT_W  samples per run. It is latched on the accepted start.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid and in_ready are both high.
- a, b  in  W  operands (same values as fed to the multiplier).
- p_approx  in  2W  multiplier output P for this a, b.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE. It is held until the next accepted start or reset.
- sample_count  out  CNT_W  samples accepted in the current run.
- err_count  out  CNT_W  samples with p_approx != a*b.
- err_max  out  2W  largest |a*b - p_approx| seen in the run.
- err_sum  out  ACC_W  sum of |a*b - p_approx| over the run.

## Operation
**States and transitions**
- IDLE: in_ready=0. On start:
  - latch num_samples into n_lat.
  - clear all statistics and sample_count.
  - go to RUN, or to DONE directly if num_samples==0.
- RUN: in_ready = (sample_count < n_lat).
  - Each handshake increments sample_count and loads stage 1.
  - The handshake that makes sample_count == n_lat moves the FSM to DRAIN.
- DRAIN: in_ready=0. Lasts exactly 2 cycles, so both pipeline stages empty, then DONE.
- DONE: done=1 and all statistics are held stable.
  - start clears the statistics and re-enters RUN (or stays in DONE if num_samples==0, with zeroed stats).
- start is ignored in RUN and DRAIN.
- n_lat is not affected by changes on num_samples during a run.

**Datapath**
- Stage 1 registers on a handshake:
  - exact = a*b, computed unsigned, 2W bits.
  - approx = p_approx.
  - v1 = 1.
- Stage 2 computes ed = (exact >= approx) ? exact-approx : approx-exact, 2W bits unsigned. When v1 is set it updates:
  - err_sum += ed (zero-extended to ACC_W).
  - err_count += (ed != 0).
  - err_max = max(err_max, ed).
- v1 clears on any cycle without a handshake.
- All arithmetic is unsigned. err_count never exceeds sample_count.

**Reset and boundaries**
- Reset values: state IDLE; in_ready, busy, done = 0; sample_count, err_count, err_max, err_sum = 0; pipeline valid bits = 0.
- rst asserted mid-run aborts immediately. Nothing partial is retained.
- rst and start in the same cycle: rst wins.
- num_samples = 2^CNT_W-1 is legal. err_sum's width covers the worst case, so no saturation logic is needed.

## Timing
- Handshake in cycle t:
  - stage 1 holds the sample in cycle t+1.
  - statistics include it in cycle t+2.
- Last handshake in cycle t:
  - DRAIN in cycles t+1 and t+2.
  - done=1 and busy=0 from cycle t+3.
  - The final statistics are visible from t+2 and stable from t+3.
- Start accepted in cycle t:
  - busy=1 and in_ready=1 (if n>0) in cycle t+1.
  - Statistics read 0 in cycle t+1.
- in_ready depends only on registered state, with no combinational path from in_valid.
- Back-to-back samples are accepted every cycle (throughput 1/cycle).
- in_valid gaps are allowed and do not affect the result.

## Test plan
- Exact-match run: reset, start with num_samples=4, 4 samples with p_approx=a*b.
  - Required: done at last-handshake+3; sample_count=4; err_count=0; err_sum=0; err_max=0.
- Known-error run: num_samples=3, samples (255,255,64768), (16,16,256), (3,5,0).
  - Required: err_count=2, err_sum=272, err_max=257.
- Handshake gaps and underestimate/overestimate: num_samples=2, in_valid toggling 1,0,0,1; samples (10,10,90) and (10,10,110).
  - Required: err_sum=20, err_max=10, err_count=2, done 3 cycles after the second handshake.
- Zero-length and restart: start with num_samples=0.
  - Required: done on the next cycle with all stats 0.
  - A start in DONE with num_samples=1 clears the stats and runs one sample.
  - A start pulse during RUN is ignored.
- Reset mid-run: rst after 2 of 5 samples.
  - Required: next cycle IDLE; all outputs 0; in_ready=0.
  - A subsequent run of 1 sample (7,9,60) gives err_sum=3, err_count=1.
- Exhaustive sweep: 65536 samples covering all (a,b) pairs, with num_samples=65535 plus one extra run of 1.
  - Required: stats equal the bench's golden model computed against the truncated multiplier output.

Source files
------------

// File: rtl/trunc_mult_err_monitor.sv
// -----------------------------------------------------------------------------
// trunc_mult_err_monitor
//
// Error-statistics stage that sits behind the 8x8 truncated Dadda multiplier.
// Each accepted sample carries the operands and the approximate product. The
// block recomputes the exact product, forms the absolute error distance and,
// over a run of num_samples samples, accumulates:
//   err_count : samples whose approximate product differs from a*b
//   err_sum   : sum of |a*b - p_approx|
//   err_max   : largest |a*b - p_approx|
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   run start pulse, honoured only in IDLE or DONE
//   num_samples  in   samples per run, latched on an accepted start
//   in_valid     in   sample valid
//   in_ready     out  sample accepted when in_valid && in_ready
//   a, b         in   operands given to the multiplier
//   p_approx     in   multiplier output for a, b
//   busy         out  run in progress (RUN or DRAIN)
//   done         out  run finished, statistics stable
//   sample_count out  samples accepted in the current run
//   err_count    out  number of erroneous samples
//   err_max      out  maximum error distance
//   err_sum      out  accumulated error distance
// -----------------------------------------------------------------------------
module trunc_mult_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 2*W + CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [2*W-1:0]     p_approx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [2*W-1:0]     err_max,
    output logic [ACC_W-1:0]   err_sum
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN1 = 3'd2,
        ST_DRAIN2 = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [CNT_W-1:0]   n_lat_q;
    logic [CNT_W-1:0]   sample_count_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               done_q;

    // stage 1
    logic               v1_q;
    logic [2*W-1:0]     exact_q;
    logic [2*W-1:0]     approx_q;

    // stage 2 (statistics)
    logic [CNT_W-1:0]   err_count_q;
    logic [2*W-1:0]     err_max_q;
    logic [ACC_W-1:0]   err_sum_q;

    logic               hs_s;
    logic               start_acc_s;
    logic [CNT_W-1:0]   sc_inc_s;
    logic [2*W-1:0]     exact_s;
    logic [2*W-1:0]     ed_s;
    logic [CNT_W-1:0]   err_count_d;
    logic [2*W-1:0]     err_max_d;
    logic [ACC_W-1:0]   err_sum_d;

    // Handshake, start acceptance, exact product and next statistics values.
    always_comb begin
        hs_s        = in_valid && in_ready_q;
        start_acc_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        sc_inc_s    = sample_count_q + CNT_ONE;
        exact_s     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        ed_s        = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
        err_sum_d   = err_sum_q + {{(ACC_W-2*W){1'b0}}, ed_s};
        err_count_d = err_count_q + ((ed_s != {(2*W){1'b0}}) ? CNT_ONE : CNT_ZERO);
        err_max_d   = (ed_s > err_max_q) ? ed_s : err_max_q;
    end

    // Run-control FSM; in_ready/busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            n_lat_q        <= CNT_ZERO;
            sample_count_q <= CNT_ZERO;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        n_lat_q        <= num_samples;
                        sample_count_q <= CNT_ZERO;
                        if (num_samples == CNT_ZERO) begin
                            state_q    <= ST_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_RUN: begin
                    if (hs_s) begin
                        sample_count_q <= sc_inc_s;
                        // The handshake that reaches n_lat closes the input side.
                        if (sc_inc_s == n_lat_q) begin
                            state_q    <= ST_DRAIN1;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN1: begin
                    state_q <= ST_DRAIN2;
                end
                ST_DRAIN2: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture exact and approximate products on each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            exact_q  <= {(2*W){1'b0}};
            approx_q <= {(2*W){1'b0}};
        end else begin
            v1_q <= hs_s;
            if (hs_s) begin
                exact_q  <= exact_s;
                approx_q <= p_approx;
            end else begin
                exact_q  <= exact_q;
                approx_q <= approx_q;
            end
        end
    end

    // Stage 2: fold the error distance of a valid stage-1 sample into the stats.
    // A start is only accepted with the pipeline empty, so clearing never drops
    // an in-flight sample of the same run.
    always_ff @(posedge clk) begin
        if (rst || start_acc_s) begin
            err_count_q <= CNT_ZERO;
            err_max_q   <= {(2*W){1'b0}};
            err_sum_q   <= {ACC_W{1'b0}};
        end else if (v1_q) begin
            err_count_q <= err_count_d;
            err_max_q   <= err_max_d;
            err_sum_q   <= err_sum_d;
        end else begin
            err_count_q <= err_count_q;
            err_max_q   <= err_max_q;
            err_sum_q   <= err_sum_q;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign err_max      = err_max_q;
    assign err_sum      = err_sum_q;

endmodule

// File: tb/tb_trunc_mult_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_trunc_mult_err_monitor
//
// Directed, table-driven bench for trunc_mult_err_monitor. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_trunc_mult_err_monitor;

    logic         clk;
    logic         rst;
    logic         start;
    logic [15:0]  num_samples;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [15:0]  p_approx;
    logic         busy;
    logic         done;
    logic [15:0]  sample_count;
    logic [15:0]  err_count;
    logic [15:0]  err_max;
    logic [31:0]  err_sum;

    int errors;
    int checks;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          gap;
    } samp_t;

    typedef struct {
        int          n;
        int          first;
        logic [15:0] exp_cnt;
        logic [31:0] exp_sum;
        logic [15:0] exp_max;
    } run_t;

    samp_t samps[9];
    run_t  runs[3];

    trunc_mult_err_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .p_approx     (p_approx),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .err_max      (err_max),
        .err_sum      (err_sum)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Truncated multiplier reference: partial-product bits in columns below 8 dropped.
    function automatic logic [15:0] trunc_mult(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if ((i + j >= 8) && x[i] && y[j])
                    s = s + (16'd1 << (i + j));
        return s;
    endfunction

    // Pulse start and check the state one cycle later.
    task automatic start_run(input int n);
        @(negedge clk);
        start       = 1'b1;
        num_samples = n[15:0];
        @(negedge clk);
        start = 1'b0;
        chk("start_busy",     64'(busy),         64'(n != 0));
        chk("start_in_ready", 64'(in_ready),     64'(n != 0));
        chk("start_done",     64'(done),         64'(n == 0));
        chk("start_scount",   64'(sample_count), 64'd0);
        chk("start_ecount",   64'(err_count),    64'd0);
        chk("start_esum",     64'(err_sum),      64'd0);
        chk("start_emax",     64'(err_max),      64'd0);
    endtask

    // Present one sample after gap idle cycles; returns right after the handshake edge.
    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] xp,
                        input int gap);
        int bound;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        p_approx = xp;
        bound    = 0;
        while (!in_ready && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles required 1", bound);
        end
        @(posedge clk);
    endtask

    // Check DRAIN timing and final statistics after the last handshake edge.
    task automatic finish_run(input int n, input logic [15:0] ecnt, input logic [31:0] esum,
                              input logic [15:0] emax);
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain1_busy",     64'(busy),     64'd1);
        chk("drain1_done",     64'(done),     64'd0);
        chk("drain1_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("drain2_busy", 64'(busy),      64'd1);
        chk("drain2_done", 64'(done),      64'd0);
        chk("t2_ecount",   64'(err_count), 64'(ecnt));
        chk("t2_esum",     64'(err_sum),   64'(esum));
        chk("t2_emax",     64'(err_max),   64'(emax));
        @(negedge clk);
        chk("done_flag",   64'(done),         64'd1);
        chk("done_busy",   64'(busy),         64'd0);
        chk("done_scount", 64'(sample_count), 64'(n));
        chk("done_ecount", 64'(err_count),    64'(ecnt));
        chk("done_esum",   64'(err_sum),      64'(esum));
        chk("done_emax",   64'(err_max),      64'(emax));
    endtask

    initial begin
        logic [15:0] m_cnt;
        logic [31:0] m_sum;
        logic [15:0] m_max;
        logic [15:0] ex;
        logic [15:0] ap;
        logic [15:0] ed;
        logic [15:0] k16;

        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = 16'd0;
        in_valid    = 1'b0;
        a           = 8'd0;
        b           = 8'd0;
        p_approx    = 16'd0;

        // exact-match run
        samps[0] = '{a: 8'd1,   b: 8'd2,   p: 16'd2,     gap: 0};
        samps[1] = '{a: 8'd200, b: 8'd3,   p: 16'd600,   gap: 0};
        samps[2] = '{a: 8'd255, b: 8'd255, p: 16'd65025, gap: 0};
        samps[3] = '{a: 8'd0,   b: 8'd77,  p: 16'd0,     gap: 0};
        // known-error run: errors 257, 0, 15
        samps[4] = '{a: 8'd255, b: 8'd255, p: 16'd64768, gap: 0};
        samps[5] = '{a: 8'd16,  b: 8'd16,  p: 16'd256,   gap: 0};
        samps[6] = '{a: 8'd3,   b: 8'd5,   p: 16'd0,     gap: 0};
        // gapped run, under- and overestimate by 10
        samps[7] = '{a: 8'd10,  b: 8'd10,  p: 16'd90,    gap: 0};
        samps[8] = '{a: 8'd10,  b: 8'd10,  p: 16'd110,   gap: 2};

        runs[0] = '{n: 4, first: 0, exp_cnt: 16'd0, exp_sum: 32'd0,   exp_max: 16'd0};
        runs[1] = '{n: 3, first: 4, exp_cnt: 16'd2, exp_sum: 32'd272, exp_max: 16'd257};
        runs[2] = '{n: 2, first: 7, exp_cnt: 16'd2, exp_sum: 32'd20,  exp_max: 16'd10};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready),     64'd0);
        chk("rst_busy",     64'(busy),         64'd0);
        chk("rst_done",     64'(done),         64'd0);
        chk("rst_scount",   64'(sample_count), 64'd0);
        chk("rst_ecount",   64'(err_count),    64'd0);
        chk("rst_esum",     64'(err_sum),      64'd0);
        chk("rst_emax",     64'(err_max),      64'd0);
        rst = 1'b0;

        for (int r = 0; r < 3; r++) begin
            start_run(runs[r].n);
            for (int i = 0; i < runs[r].n; i++)
                send(samps[runs[r].first + i].a, samps[runs[r].first + i].b,
                     samps[runs[r].first + i].p, samps[runs[r].first + i].gap);
            finish_run(runs[r].n, runs[r].exp_cnt, runs[r].exp_sum, runs[r].exp_max);
        end

        // Zero-length run from DONE, then a one-sample run with a start during RUN.
        start_run(0);
        start_run(1);
        @(negedge clk);
        start       = 1'b1;
        num_samples = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_busy",     64'(busy),         64'd1);
        chk("ign_start_in_ready", 64'(in_ready),     64'd1);
        chk("ign_start_done",     64'(done),         64'd0);
        chk("ign_start_scount",   64'(sample_count), 64'd0);
        send(8'd2, 8'd3, 16'd5, 0);
        finish_run(1, 16'd1, 32'd1, 16'd1);

        // Reset after 2 of 5 samples, with a simultaneous start.
        start_run(5);
        send(8'd100, 8'd100, 16'd0, 0);
        send(8'd50,  8'd50,  16'd0, 0);
        @(negedge clk);
        in_valid    = 1'b0;
        rst         = 1'b1;
        start       = 1'b1;
        num_samples = 16'd3;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready),     64'd0);
        chk("mid_rst_busy",     64'(busy),         64'd0);
        chk("mid_rst_done",     64'(done),         64'd0);
        chk("mid_rst_scount",   64'(sample_count), 64'd0);
        chk("mid_rst_ecount",   64'(err_count),    64'd0);
        chk("mid_rst_esum",     64'(err_sum),      64'd0);
        chk("mid_rst_emax",     64'(err_max),      64'd0);
        rst   = 1'b0;
        start = 1'b0;
        start_run(1);
        send(8'd7, 8'd9, 16'd60, 0);
        finish_run(1, 16'd1, 32'd3, 16'd3);

        // Exhaustive sweep: 65535 pairs, then the final pair in a run of 1.
        m_cnt = 16'd0;
        m_sum = 32'd0;
        m_max = 16'd0;
        start_run(65535);
        for (int k = 0; k < 65535; k++) begin
            k16 = k[15:0];
            ex  = 16'(k16[15:8]) * 16'(k16[7:0]);
            ap  = trunc_mult(k16[15:8], k16[7:0]);
            ed  = (ex >= ap) ? ex - ap : ap - ex;
            if (ed != 16'd0) m_cnt = m_cnt + 16'd1;
            m_sum = m_sum + 32'(ed);
            if (ed > m_max) m_max = ed;
            send(k16[15:8], k16[7:0], ap, 0);
        end
        finish_run(65535, m_cnt, m_sum, m_max);

        start_run(1);
        ex = 16'd65025;
        ap = trunc_mult(8'd255, 8'd255);
        ed = (ex >= ap) ? ex - ap : ap - ex;
        send(8'd255, 8'd255, ap, 0);
        finish_run(1, (ed != 16'd0) ? 16'd1 : 16'd0, 32'(ed), ed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
